md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage of the pipelined CPU.
- Consumes the 5-bit ALU operation code produced by the decode controller and latched in ID/EX; codes with op[4]=1 and op[3:1]!=000 are M-extension ops.
- Holds the pipeline with a stall request while computing, then presents a 32-bit result for the EX/MEM register.
- Shift ops (10000 srl, 10001 sra) belong to the ALU and are ignored here.

Parameters:
- XLEN, 32, operand/result width.
- EARLY_OUT, 1, when 1 divide-by-zero and signed overflow finish in one cycle without iterating.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  ID/EX holds a valid instruction
- op  in  5  ALU op code: 10010 mul, 10011 mulh, 10100 mulhsu, 10101 mulhu, 10110 div, 10111 divu, 11000 rem, 11001 remu
- a  in  XLEN  rs1 operand, already forwarded
- b  in  XLEN  rs2 operand, already forwarded
- flush  in  1  kill the in-flight op (branch/jump redirect)
- stall  out  1  freeze PC, IF/ID and ID/EX
- busy  out  1  FSM not IDLE
- done  out  1  result valid this cycle, one-cycle pulse
- result  out  XLEN  result, held until the next accepted op

Behaviour:
- Reset, or flush when not in DONE: state=IDLE, counter=0, done=0, busy=0, result=0 (reset only; flush leaves result unchanged), stall=0 from the next cycle.
- md_op = op is one of the 8 codes above. accept = start & md_op & state==IDLE & ~flush.
- stall is combinational: (accept) | (state==CALC). It is low in DONE so the pipeline advances that cycle.
- FSM:
  - IDLE -> CALC on accept: latch |a|, |b| per signedness, sign flags, op; counter=0.
  - IDLE -> DONE on accept when EARLY_OUT=1 and the op is a special divide case.
  - CALC: one radix-2 step per cycle; counter increments; after XLEN steps (counter==XLEN-1) -> DONE.
  - DONE: done=1 and result valid for exactly one cycle -> IDLE. start is not re-sampled in DONE.
- Latency: accept in cycle N; done in cycle N+XLEN+1 (33 for 32-bit). Special case: done in N+1.
- Multiply: shift-add over the 2*XLEN product of the unsigned magnitudes; the product is negated if signs differ.
  - mul returns the low half. mulh/mulhsu/mulhu return the high half.
  - Signedness: mulh s×s, mulhsu s×u, mulhu u×u.
- Divide: restoring divide on the unsigned magnitudes.
  - Quotient is negated if the signs differ (signed only).
  - Remainder takes the sign of the dividend.
- Special cases (RISC-V mandated):
  - b==0: div/divu=all ones, rem/remu=a.
  - div a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, rem 0.
  - With EARLY_OUT=0 the iterative path must produce the identical values.
- flush in CALC: return to IDLE next cycle, no done pulse. flush in DONE: ignored, done still pulses.
- start deasserted mid-CALC: ignored; the op completes.

Optional Feature:
- Macro: MD_FAST_MUL_EN.
- Defined: multiply ops use a combinational 33×33 signed product registered once. IDLE -> DONE, latency 1, stall high only in the accept cycle. Divide is unchanged.
- Undefined: multiply is iterative as above, latency XLEN+1.

Decomposition:
- Shared package holds:
  - MD_* op-code constants (the 8 codes above), kept consistent with the ALU op encoding used by the controller.
  - State encoding IDLE=2'b00, CALC=2'b01, DONE=2'b10.
- One sub-module is natural: md_div_core, an iterative restoring divider with its own step counter. md_unit keeps the FSM, sign handling, multiplier and result mux.

Test Plan:
- mul a=7, b=-3 (0xFFFFFFFD) -> stall high for 33 cycles; done in cycle 33; result=0xFFFFFFEB. mulh on the same operands -> 0xFFFFFFFF.
- mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE; mulhsu a=-1, b=2 -> 0xFFFFFFFF.
- div a=-20, b=6 -> quotient 0xFFFFFFFD; rem -> 0xFFFFFFFE; divu a=20, b=6 -> 3; remu -> 2.
- div b=0, a=5 -> done one cycle after accept, result 0xFFFFFFFF; remu b=0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0.
- flush asserted 10 cycles into a div -> busy and stall drop the next cycle, no done pulse; a following mul is accepted at once and gives the correct result.
- op=00011 (add) or 10000 (srl) with start=1 -> stall=0, busy=0. Reset asserted mid-CALC -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared op codes, FSM encoding and operand-class helpers for md_unit.
package md_pkg;

  localparam logic [4:0] MD_MUL    = 5'b10010;
  localparam logic [4:0] MD_MULH   = 5'b10011;
  localparam logic [4:0] MD_MULHSU = 5'b10100;
  localparam logic [4:0] MD_MULHU  = 5'b10101;
  localparam logic [4:0] MD_DIV    = 5'b10110;
  localparam logic [4:0] MD_DIVU   = 5'b10111;
  localparam logic [4:0] MD_REM    = 5'b11000;
  localparam logic [4:0] MD_REMU   = 5'b11001;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  function automatic logic is_md(input logic [4:0] op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
                      MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_mul(input logic [4:0] op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU};
  endfunction

  function automatic logic sgn_a(input logic [4:0] op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic sgn_b(input logic [4:0] op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/md_div_core.sv
// md_div_core: radix-2 restoring divider on unsigned magnitudes.
// Its step counter also paces the iterative multiplier in md_unit.
module md_div_core
  import md_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic            last_o,
  output logic [XLEN-1:0] q_nx_o,
  output logic [XLEN-1:0] r_nx_o
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] q_q, r_q, d_q;
  logic [XLEN:0]   sh;
  logic            ge;

  assign sh     = {r_q, q_q[XLEN-1]};
  assign ge     = sh >= {1'b0, d_q};
  assign r_nx_o = ge ? sh[XLEN-1:0] - d_q : sh[XLEN-1:0];
  assign q_nx_o = {q_q[XLEN-2:0], ge};
  assign last_o = cnt_q == CW'(XLEN - 1);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      q_q   <= dvd_i;
      r_q   <= '0;
      d_q   <= dvs_i;
    end else if (step_i) begin
      cnt_q <= cnt_q + 1'b1;
      q_q   <= q_nx_o;
      r_q   <= r_nx_o;
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit with pipeline stall request.
// Define MD_FAST_MUL_EN for a one-cycle registered 33x33 multiplier.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [1:0]        state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic [2*XLEN-1:0] p_q, p_d, p_nx, prod;
  logic [XLEN-1:0]   mc_q, mc_d, res_q, res_d;
  logic [XLEN-1:0]   ma, mb, q_nx, r_nx, quo, rem;
  logic [XLEN-1:0]   spec_res, calc_res;
  logic [XLEN:0]     sum;
  logic              accept, sa, sb, b_zero, ovf, special, last;

  assign accept = start & is_md(op) & (state_q == S_IDLE) & ~flush & ~rst;
  assign sa     = sgn_a(op) & a[XLEN-1];
  assign sb     = sgn_b(op) & b[XLEN-1];
  assign ma     = sa ? -a : a;
  assign mb     = sb ? -b : b;
  assign b_zero = b == '0;
  assign ovf    = (op == MD_DIV || op == MD_REM) && b == '1
                && a == {1'b1, {(XLEN-1){1'b0}}};
  assign special = (EARLY_OUT != 0) & ~is_mul(op) & (b_zero | ovf);
  assign spec_res = (op == MD_DIV || op == MD_DIVU)
                  ? (b_zero ? '1 : a) : (b_zero ? a : '0);

  // Shift-add: conditionally add multiplicand to the high half, shift right.
  assign sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, mc_q} : '0);
  assign p_nx = {sum, p_q[XLEN-1:1]};
  assign prod = neg_q ? -p_nx : p_nx;
  assign quo  = neg_q ? -q_nx : q_nx;
  assign rem  = rneg_q ? -r_nx : r_nx;

  always_comb begin
    calc_res = rem;
    unique case (op_q)
      MD_MUL:                       calc_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              calc_res = quo;
      default:                      calc_res = rem;
    endcase
  end

`ifdef MD_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fp;
  logic [XLEN-1:0]          fast_res;

  assign fa = {sgn_a(op) & a[XLEN-1], a};
  assign fb = {sgn_b(op) & b[XLEN-1], b};
  assign fp = fa * fb;
  assign fast_res = (op == MD_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    p_d     = p_q;
    mc_d    = mc_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        op_d   = op;
        neg_d  = (sa ^ sb) & (is_mul(op) | ~b_zero);
        rneg_d = sa;
        p_d    = {{XLEN{1'b0}}, mb};
        mc_d   = ma;
        if (special) begin
          state_d = S_DONE;
          res_d   = spec_res;
        end
`ifdef MD_FAST_MUL_EN
        else if (is_mul(op)) begin
          state_d = S_DONE;
          res_d   = fast_res;
        end
`endif
        else begin
          state_d = S_CALC;
        end
      end
      S_CALC: if (flush) begin
        state_d = S_IDLE;
      end else begin
        p_d = p_nx;
        if (last) begin
          state_d = S_DONE;
          res_d   = calc_res;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      p_q     <= '0;
      mc_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      p_q     <= p_d;
      mc_q    <= mc_d;
      res_q   <= res_d;
    end
  end

  md_div_core #(.XLEN(XLEN)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (flush & (state_q != S_DONE)),
    .load_i (accept),
    .step_i (state_q == S_CALC),
    .dvd_i  (ma),
    .dvs_i  (mb),
    .last_o (last),
    .q_nx_o (q_nx),
    .r_nx_o (r_nx)
  );

  assign stall  = accept | (state_q == S_CALC);
  assign busy   = state_q != S_IDLE;
  assign done   = state_q == S_DONE;
  assign result = res_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed table, corner sequences and randomized ops vs a reference model.
module tb_md_unit;

  localparam logic [4:0] OP_MUL    = 5'b10010;
  localparam logic [4:0] OP_MULH   = 5'b10011;
  localparam logic [4:0] OP_MULHSU = 5'b10100;
  localparam logic [4:0] OP_MULHU  = 5'b10101;
  localparam logic [4:0] OP_DIV    = 5'b10110;
  localparam logic [4:0] OP_DIVU   = 5'b10111;
  localparam logic [4:0] OP_REM    = 5'b11000;
  localparam logic [4:0] OP_REMU   = 5'b11001;
`ifdef MD_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        stall, busy, done;
  logic [31:0] result;
  int          npass = 0;
  int          ntot = 0;
  logic [31:0] last_res;

  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  function automatic logic is_mul_op(input logic [4:0] o);
    return o == OP_MUL || o == OP_MULH || o == OP_MULHSU || o == OP_MULHU;
  endfunction

  function automatic logic [31:0] ref_md(input logic [4:0] o,
                                         input logic [31:0] x, y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    p  = '0;
    case (o)
      OP_MUL:    begin p = sx * sy; return p[31:0];  end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * uy; return p[63:32]; end
      OP_MULHU:  begin p = ux * uy; return p[63:32]; end
      OP_DIV:    begin
        if (y == 0) return 32'hFFFFFFFF;
        p = sx / sy; return p[31:0];
      end
      OP_REM:    begin
        if (y == 0) return x;
        p = sx % sy; return p[31:0];
      end
      OP_DIVU:   return (y == 0) ? 32'hFFFFFFFF : x / y;
      default:   return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] o, input logic [31:0] x, y);
    if (is_mul_op(o)) return MLAT;
    if (y == 0) return 1;
    if ((o == OP_DIV || o == OP_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF)
      return 1;
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic do_op(input string nm, input logic [4:0] o,
                       input logic [31:0] x, y, rexp, input int lexp);
    int lat, nst;
    logic [31:0] res;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 nst = int'(stall);
    @(posedge clk);
    #1 start = 1'b0; op = 5'b00000;
    lat = 0; res = 'x;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      nst += int'(stall);
      if (done) begin res = result; break; end
    end
    chk({nm, ".result"}, res, rexp);
    chk({nm, ".latency"}, lat, lexp);
    chk({nm, ".stall_cycles"}, nst, lexp);
    @(negedge clk);
    chk({nm, ".done_pulse"}, {31'b0, done}, 32'd0);
    chk({nm, ".held"}, result, rexp);
    last_res = rexp;
  endtask

  vec_t tbl[13];

  initial begin
    logic [31:0] x, y;
    logic [4:0]  o;
    int ndone;
    logic [4:0] ops[8];
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    tbl[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MLAT};
    tbl[1]  = '{OP_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, MLAT};
    tbl[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MLAT};
    tbl[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MLAT};
    tbl[4]  = '{OP_DIV,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 33};
    tbl[5]  = '{OP_REM,    32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 33};
    tbl[6]  = '{OP_DIVU,   32'd20,       32'd6,        32'd3,        33};
    tbl[7]  = '{OP_REMU,   32'd20,       32'd6,        32'd2,        33};
    tbl[8]  = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
    tbl[9]  = '{OP_REMU,   32'd5,        32'd0,        32'd5,        1};
    tbl[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    tbl[12] = '{OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.stall",  {31'b0, stall}, 32'd0);
    chk("reset.busy",   {31'b0, busy},  32'd0);
    chk("reset.done",   {31'b0, done},  32'd0);
    chk("reset.result", result,         32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].res, tbl[i].lat);

    // Non-M ops must be ignored.
    @(negedge clk);
    start = 1'b1; op = 5'b00011; a = $urandom; b = $urandom;
    #1 chk("add.stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    chk("add.busy", {31'b0, busy}, 32'd0);
    op = 5'b10000;
    #1 chk("srl.stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    chk("srl.busy", {31'b0, busy}, 32'd0);
    start = 1'b0; op = '0;

    // Flush 10 cycles into a divide.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; op = '0;
    repeat (10) @(negedge clk);
    chk("flush.busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush.busy", {31'b0, busy}, 32'd0);
    chk("flush.stall", {31'b0, stall}, 32'd0);
    chk("flush.result_kept", result, last_res);
    x = $urandom; y = $urandom;
    do_op("flush.mul", OP_MUL, x, y, ref_md(OP_MUL, x, y), MLAT);

    // Reset in the middle of an iterative divide.
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = $urandom; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; op = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.stall",  {31'b0, stall}, 32'd0);
    chk("midrst.busy",   {31'b0, busy},  32'd0);
    chk("midrst.done",   {31'b0, done},  32'd0);
    chk("midrst.result", result,         32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("midrst.no_done", ndone, 0);
    x = $urandom; y = $urandom;
    do_op("midrst.mulhu", OP_MULHU, x, y, ref_md(OP_MULHU, x, y), MLAT);

    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 7)];
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: begin x = $urandom_range(0, 200); y = $urandom_range(0, 20) - 10; end
        default: ;
      endcase
      do_op($sformatf("rand%0d_op%b", i, o), o, x, y, ref_md(o, x, y), ref_lat(o, x, y));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
